bcd_down_timer: RTL and testbench
=================================

// Module: bcd_down_timer
// PURPOSE
//   Loadable two-digit BCD countdown timer: the down-counting counterpart of the up-counting BCD counter.
//   Counts a preset 00..99 value down to 00 at a prescaled tick rate and pulses done on expiry.
//   Digit outputs use the same ones/tens nibble format as the up counter, so display decoders are shared.
// PARAMETERS
//   TICK_DIV  4  clock cycles per decrement while running; legal range 1..65535
// PORTS
//   clk        in   1  system clock, all logic on rising edge
//   reset      in   1  synchronous, active-high reset
//   load       in   1  one-cycle strobe: preset count from load_tens/load_ones
//   load_tens  in   4  BCD tens digit to preset (0..9)
//   load_ones  in   4  BCD ones digit to preset (0..9)
//   start      in   1  begin or resume counting
//   pause      in   1  suspend counting, hold count and prescaler phase
//   cnt_ones   out  4  current BCD ones digit
//   cnt_tens   out  4  current BCD tens digit
//   running    out  1  high while state == RUN
//   done       out  1  one-cycle pulse on reaching 00
//   load_err   out  1  one-cycle pulse: load rejected (a digit > 9)
// BEHAVIOUR
//   Reset: one clock; reset is synchronous and active-high.
//     Sampled at a rising edge, it forces cnt=00, state IDLE, prescaler=0 and running/done/load_err=0.
//   States: IDLE, RUN, PAUSED, DONE. All outputs are registered.
//   Input priority per edge: reset > load > pause > start.
//   load, both digits <= 9: cnt <= preset; state -> IDLE from any state; prescaler <= 0.
//   load, either digit > 9: cnt and state unchanged; load_err = 1 next cycle only.
//   start in IDLE with cnt != 00: -> RUN; prescaler <= 0.
//   start in PAUSED with cnt != 00: -> RUN; prescaler keeps its value.
//   start with cnt == 00, or start in RUN or DONE: ignored.
//   pause in RUN: -> PAUSED. pause in any other state: no effect. start+pause together: pause wins.
//   RUN prescaler: counts 0..TICK_DIV-1.
//     The edge on which it wraps from TICK_DIV-1 to 0 is a tick.
//     Result: first decrement TICK_DIV edges after the start edge, then one every TICK_DIV edges.
//   Tick decrement:
//     ones != 0: ones - 1.
//     ones == 0: ones <= 9 and tens - 1 (e.g. 10 -> 09, 20 -> 19).
//   Tick yielding 00: state -> DONE on the same edge.
//     done = 1 for exactly the first cycle cnt shows 00; running = 0 from that cycle.
//   DONE: holds cnt=00 until a valid load (-> IDLE) or reset. Never wraps to 99 and never underflows.
//   Digits never leave 0..9 under any input sequence.
//   running = 1 iff state is RUN. In PAUSED, IDLE and DONE, cnt is held.
// TESTING
//   TICK_DIV=1, load 15, start -> cnt 14,13,..,10,09,..,00 on successive edges; done pulses 1 cycle with cnt=00 (15 edges after start).
//   TICK_DIV=4, load 20, start -> first change 20->19 on the 4th edge after start; 19->18 four edges later; running=1 throughout.
//   load tens=1 ones=A (0x1A) while cnt=07 -> load_err 1 cycle; cnt stays 07; state unchanged.
//   TICK_DIV=4, run 2 cycles, pause 5 cycles, start -> next decrement 2 edges after resume (phase kept); cnt frozen while paused.
//   start+pause same cycle in IDLE with cnt=05 -> remains IDLE; start with cnt=00 -> no RUN, no done.
//   reset mid-RUN at cnt=42 -> next cycle cnt=00, running=0, done=0; load 99 + start during RUN -> IDLE at 99, then RUN.

Source files
------------

// File: rtl/bcd_down_timer.sv
// bcd_down_timer: loadable two-digit BCD countdown with prescaled tick and done pulse.
// Digit nibbles match the up-counter format so display decoders can be shared.
module bcd_down_timer #(
    parameter int TICK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_tens,
    input  logic [3:0] load_ones,
    input  logic       start,
    input  logic       pause,
    output logic [3:0] cnt_ones,
    output logic [3:0] cnt_tens,
    output logic       running,
    output logic       done,
    output logic       load_err
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;
    state_t state;
    logic [15:0] presc;
    logic load_ok, zero, last, tick;
    assign load_ok = (load_tens <= 4'd9) && (load_ones <= 4'd9);
    assign zero = (cnt_tens == 4'd0) && (cnt_ones == 4'd0);
    assign last = (cnt_tens == 4'd0) && (cnt_ones == 4'd1);
    assign tick = presc == 16'(TICK_DIV - 1);
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            presc    <= '0;
            cnt_ones <= '0;
            cnt_tens <= '0;
            running  <= 1'b0;
            done     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            done     <= 1'b0;
            load_err <= 1'b0;
            if (load) begin
                if (load_ok) begin
                    cnt_tens <= load_tens;
                    cnt_ones <= load_ones;
                    state    <= IDLE;
                    running  <= 1'b0;
                    presc    <= '0;
                end else begin
                    load_err <= 1'b1;
                end
            end else if (pause) begin
                if (state == RUN) begin
                    state   <= PAUSED;
                    running <= 1'b0;
                end
            end else if (state == RUN) begin
                if (tick) begin
                    presc <= '0;
                    // Borrow from tens when ones is 0; RUN is never entered at 00
                    if (cnt_ones != 4'd0) begin
                        cnt_ones <= cnt_ones - 4'd1;
                    end else if (cnt_tens != 4'd0) begin
                        cnt_ones <= 4'd9;
                        cnt_tens <= cnt_tens - 4'd1;
                    end
                    if (last || zero) begin
                        state   <= DONE;
                        running <= 1'b0;
                        done    <= last;
                    end
                end else begin
                    presc <= presc + 16'd1;
                end
            end else if (start && !zero && (state == IDLE || state == PAUSED)) begin
                state   <= RUN;
                running <= 1'b1;
                if (state == IDLE) presc <= '0;
            end
        end
    end
endmodule

// File: tb/tb_bcd_down_timer.sv
// tb_bcd_down_timer: directed and random checks of two timer instances (TICK_DIV 1 and 4)
// against a count-as-integer reference model.
module tb_bcd_down_timer;
    logic clk = 1'b0;
    logic reset = 1'b1, load = 1'b0, start = 1'b0, pause = 1'b0;
    logic [3:0] load_tens = '0, load_ones = '0;
    logic [3:0] ones_a, tens_a, ones_b, tens_b;
    logic run_a, done_a, err_a, run_b, done_b, err_b;
    int vectors = 0, miscompares = 0;
    int divs [2] = '{1, 4};
    int mval [2], mmode [2], mph [2];
    bit mdn [2], mle [2];
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;

    always #5 clk = ~clk;

    bcd_down_timer #(.TICK_DIV(1)) dut_a (
        .clk(clk), .reset(reset), .load(load), .load_tens(load_tens), .load_ones(load_ones),
        .start(start), .pause(pause), .cnt_ones(ones_a), .cnt_tens(tens_a),
        .running(run_a), .done(done_a), .load_err(err_a));
    bcd_down_timer #(.TICK_DIV(4)) dut_b (
        .clk(clk), .reset(reset), .load(load), .load_tens(load_tens), .load_ones(load_ones),
        .start(start), .pause(pause), .cnt_ones(ones_b), .cnt_tens(tens_b),
        .running(run_b), .done(done_b), .load_err(err_b));

    function automatic logic [10:0] obs(int i);
        return (i == 0) ? {tens_a, ones_a, run_a, done_a, err_a}
                        : {tens_b, ones_b, run_b, done_b, err_b};
    endfunction

    function automatic logic [10:0] expv(int i);
        return {4'(mval[i] / 10), 4'(mval[i] % 10), mmode[i] == M_RUN, mdn[i], mle[i]};
    endfunction

    task automatic check(string tag, logic [10:0] o, logic [10:0] e);
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // Reference: the count is a plain integer 0..99; a tick subtracts one.
    task automatic model(int i);
        if (reset) begin
            mval[i] = 0; mmode[i] = M_IDLE; mph[i] = 0; mdn[i] = 0; mle[i] = 0;
            return;
        end
        mdn[i] = 0; mle[i] = 0;
        if (load) begin
            if (load_tens <= 9 && load_ones <= 9) begin
                mval[i] = int'(load_tens) * 10 + int'(load_ones);
                mmode[i] = M_IDLE; mph[i] = 0;
            end else mle[i] = 1;
        end else if (pause) begin
            if (mmode[i] == M_RUN) mmode[i] = M_PAUSED;
        end else if (mmode[i] == M_RUN) begin
            mph[i] = (mph[i] + 1) % divs[i];
            if (mph[i] == 0) begin
                mval[i] = mval[i] - 1;
                if (mval[i] == 0) begin mmode[i] = M_DONE; mdn[i] = 1; end
            end
        end else if (start && mval[i] != 0 && (mmode[i] == M_IDLE || mmode[i] == M_PAUSED)) begin
            if (mmode[i] == M_IDLE) mph[i] = 0;
            mmode[i] = M_RUN;
        end
    endtask

    task automatic drive(bit r, bit l, int lt, int lo, bit s, bit p);
        reset = r; load = l; load_tens = 4'(lt); load_ones = 4'(lo); start = s; pause = p;
        @(posedge clk);
        model(0); model(1);
        #1;
        check("model_a", obs(0), expv(0));
        check("model_b", obs(1), expv(1));
        reset = 0; load = 0; start = 0; pause = 0;
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) drive(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0);
        check("reset_a", obs(0), 11'h000);
        // Load 15 and count down
        drive(0, 1, 1, 5, 0, 0);
        check("load15", obs(0), {8'h15, 3'b000});
        drive(0, 0, 0, 0, 1, 0);
        idle(14);
        check("div1_at01", obs(0), {8'h01, 3'b100});
        idle(1);
        check("div1_done", obs(0), {8'h00, 3'b010});
        check("div4_after15", obs(1), {8'h12, 3'b100});
        idle(2);
        check("div1_hold00", obs(0), {8'h00, 3'b000});
        // 20 -> 19 on the fourth edge
        drive(0, 1, 2, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0);
        idle(3);
        check("div4_edge3", obs(1), {8'h20, 3'b100});
        idle(1);
        check("div4_edge4", obs(1), {8'h19, 3'b100});
        idle(4);
        check("div4_edge8", obs(1), {8'h18, 3'b100});
        // Rejected load
        drive(0, 1, 0, 7, 0, 0);
        drive(0, 1, 1, 10, 0, 0);
        check("load_err", obs(1), {8'h07, 3'b001});
        idle(1);
        check("load_err_clr", obs(1), {8'h07, 3'b000});
        // Pause keeps prescaler phase
        drive(0, 1, 2, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0);
        idle(2);
        for (int k = 0; k < 5; k++) drive(0, 0, 0, 0, 0, 1);
        check("paused", obs(1), {8'h20, 3'b000});
        drive(0, 0, 0, 0, 1, 0);
        idle(1);
        check("resume1", obs(1), {8'h20, 3'b100});
        idle(1);
        check("resume2", obs(1), {8'h19, 3'b100});
        // start+pause in IDLE, start at 00
        drive(0, 1, 0, 5, 0, 0);
        drive(0, 0, 0, 0, 1, 1);
        check("start_pause", obs(1), {8'h05, 3'b000});
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0);
        idle(1);
        check("start_at00", obs(0), {8'h00, 3'b000});
        // Reset mid-run
        drive(0, 1, 4, 2, 0, 0);
        drive(0, 0, 0, 0, 1, 0);
        idle(1);
        drive(1, 0, 0, 0, 0, 0);
        check("reset_mid_b", obs(1), 11'h000);
        // Load 99 + start during RUN
        drive(0, 1, 5, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0);
        idle(2);
        drive(0, 1, 9, 9, 1, 0);
        check("load99_run", obs(1), {8'h99, 3'b000});
        drive(0, 0, 0, 0, 1, 0);
        check("start99", obs(1), {8'h99, 3'b100});
        // Random traffic
        for (int k = 0; k < 800; k++) begin
            int d = $urandom_range(0, 99);
            bit l = ($urandom_range(0, 15) == 0);
            int lt = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 9);
            int lo = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 9);
            drive(d == 0, l, lt, lo, $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
